ysyx_24090005_lsu: RTL and testbench
====================================

YSYX_24090005_LSU -- requirements
Module: ysyx_24090005_lsu

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles in WAIT before an error response is forced; legal range 1..255.
REQ-002 Ports (name direction width meaning), clock and reset first:
- clk in 1: single clock; all state updates on rising edge.
- rst in 1: reset, asynchronous, active-low.
- req_valid in 1: upstream (ALU) has a memory op.
- req_ready out 1: LSU can accept.
- req_wen in 1: 1 = store, 0 = load.
- req_funct3 in 3: RV32I load/store funct3.
- req_addr in 32: effective address from ALU.
- req_wdata in 32: store data, unshifted.
- req_rd in 5: load destination register.
- mem_valid out 1: memory request.
- mem_ready in 1: memory accepts the request.
- mem_wen out 1: write request.
- mem_addr out 32: word-aligned address.
- mem_wdata out 32: lane-shifted store data.
- mem_wmask out 4: byte-lane enables.
- mem_rvalid in 1: read data / write acknowledge.
- mem_rdata in 32: read word.
- rsp_valid out 1: result to writeback.
- rsp_ready in 1: writeback accepts.
- rsp_rd out 5: destination register.
- rsp_data out 32: extended load data; 0 for stores.
- rsp_wen out 1: register write enable; 1 only for a successful load.
- rsp_err out 1: access fault (illegal funct3, misaligned, timeout).

Function
REQ-003 FSM states IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-004 IDLE, req_valid=1: latch all req_* fields; legal op -> REQ; illegal op -> RESP with rsp_err=1 and no memory access.
REQ-005 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-006 REQ: mem_valid=1 with mem_addr, mem_wen, mem_wdata and mem_wmask stable until mem_ready=1; then -> WAIT. REQ has no timeout.
REQ-007 mem_addr={addr[31:2],2'b00}; wmask SB=0001<<addr[1:0], SH=0011<<{addr[1],1'b0}, SW=1111; wdata byte/half replicated to all lanes; loads drive wmask=0000.
REQ-008 WAIT: counter starts at 0 and increments each cycle; mem_rvalid=1 -> capture and -> RESP; counter reaching TIMEOUT_CYC without mem_rvalid -> RESP with rsp_err=1, rsp_wen=0.
REQ-009 mem_rvalid is ignored outside WAIT, so a late response after timeout is dropped.
REQ-010 Load data: select byte/half by address offset; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; registered in RESP.
REQ-011 RESP: rsp_valid=1, outputs held stable until rsp_ready=1; then -> IDLE. The next request can be accepted no earlier than the following cycle.
REQ-012 Minimum latency, accept (cycle 0) to rsp_valid: 3 cycles, when mem_ready=1 in cycle 1 and mem_rvalid=1 in cycle 2.
REQ-013 rsp_rd=latched req_rd for loads, 0 for stores and for errors.

Reset
REQ-014 rst=0 asynchronously forces IDLE, counter=0, and all outputs 0 except req_ready; req_ready=1 once rst=1.
REQ-015 Reset in any state aborts the operation: no response is issued, and any pending memory response is dropped per REQ-009.

Configuration
REQ-016 Macro YSYX_24090005_LSU_MISALIGN_EN.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 -> RESP with rsp_err=1 and no memory access.
- Undefined: the offending low address bits are forced to natural alignment (LH/SH use addr[1], LW/SW use offset 0), the access proceeds, and rsp_err is never set for misalignment.

Verification
REQ-017 LB at addr 0x80000003, mem_rdata 0x8a000000 -> mem_addr 0x80000000, rsp_data 0xffffff8a, rsp_wen=1.
REQ-018 SH at 0x80000002, wdata 0x1234abcd -> mem_wmask 1100, mem_wdata 0xabcdabcd, rsp_wen=0, rsp_data=0.
REQ-019 LW at 0x80000001 -> with macro: rsp_err=1 and mem_valid never asserted; without macro: mem_addr 0x80000000 and rsp_err=0.
REQ-020 Load, mem_rvalid withheld, TIMEOUT_CYC=4 -> rsp_err=1 exactly 4 cycles after entering WAIT; a later mem_rvalid pulse causes no second response.
REQ-021 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable; req_ready=0 throughout.
REQ-022 rst=0 asserted in WAIT -> all outputs 0 immediately, req_ready=1 after release, no rsp_valid issued.

Source files
------------

// File: rtl/ysyx_24090005_lsu.sv
// ysyx_24090005_lsu: RV32I load/store unit sitting between the ALU and a
// simple valid/ready memory port. It handles one request at a time.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_*           operation from the ALU (valid/ready handshake)
//   mem_*           word-aligned memory request plus read data / write ack
//   rsp_*           writeback result (valid/ready handshake)
//
// Parameter TIMEOUT_CYC (1..255): cycles allowed in WAIT before an error
// response is forced.
//
// Build option YSYX_24090005_LSU_MISALIGN_EN:
//   defined   - misaligned halfword/word accesses fault without touching memory.
//   undefined - the low address bits are forced to natural alignment and the
//               access proceeds.
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | memory request presented, waiting for mem_ready
// WAIT  | waiting for mem_rvalid, timeout counter running
// RESP  | result presented, waiting for rsp_ready
module ysyx_24090005_lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        rsp_wen,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        wen_q, wen_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_wen_q, rsp_wen_d;
    logic        rsp_err_q, rsp_err_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;

    logic        access_ok;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [3:0]  st_mask;
    logic [31:0] st_data;

    function automatic logic legal_op(input logic wen, input logic [2:0] f3);
        if (wen) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

`ifdef YSYX_24090005_LSU_MISALIGN_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction
    assign access_ok = legal_op(req_wen, req_funct3) && !misaligned(req_funct3, req_addr[1:0]);
`else
    assign access_ok = legal_op(req_wen, req_funct3);
`endif

    // Byte offset after natural alignment; with misalign checking enabled the
    // forcing is a no-op because misaligned ops never reach memory.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   off = addr_q[1:0];
            2'b01:   off = {addr_q[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    always_comb begin
        case (off)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_mask = 4'b0001 << off;
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << off;
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_wen_d  = rsp_wen_q;
        rsp_err_d  = rsp_err_q;
        rsp_rd_d   = rsp_rd_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d    = req_wen;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rd_d     = req_rd;
                    if (access_ok) begin
                        state_d = REQ;
                    end else begin
                        state_d    = RESP;
                        rsp_data_d = 32'd0;
                        rsp_wen_d  = 1'b0;
                        rsp_err_d  = 1'b1;
                        rsp_rd_d   = 5'd0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    state_d    = RESP;
                    rsp_data_d = wen_q ? 32'd0 : ld_data;
                    rsp_wen_d  = !wen_q;
                    rsp_err_d  = 1'b0;
                    rsp_rd_d   = wen_q ? 5'd0 : rd_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = RESP;
                    rsp_data_d = 32'd0;
                    rsp_wen_d  = 1'b0;
                    rsp_err_d  = 1'b1;
                    rsp_rd_d   = 5'd0;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wen_q      <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 8'd0;
            rsp_data_q <= 32'd0;
            rsp_wen_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_rd_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_wen_q  <= rsp_wen_d;
            rsp_err_q  <= rsp_err_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    // req_ready is gated by rst so it reads 0 while reset is held.
    assign req_ready = (state_q == IDLE) && rst;
    assign mem_valid = (state_q == REQ);
    assign mem_wen   = mem_valid && wen_q;
    assign mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = mem_wen ? st_data : 32'd0;
    assign mem_wmask = mem_wen ? st_mask : 4'd0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_valid ? rsp_data_q : 32'd0;
    assign rsp_wen   = rsp_valid && rsp_wen_q;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign rsp_rd    = rsp_valid ? rsp_rd_q : 5'd0;

endmodule

// File: tb/tb_ysyx_24090005_lsu.sv
module tb_ysyx_24090005_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        req_ready, mem_valid, mem_wen, rsp_valid, rsp_wen, rsp_err;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [3:0]  mem_wmask;
    logic [4:0]  rsp_rd;

    int errors = 0;
    int checks = 0;

    ysyx_24090005_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .rsp_wen(rsp_wen), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, naturally aligned lane offset,
    // arithmetic extraction/extension and replication by multiplication.
    task automatic model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                         output logic acc, output logic e, output logic rw,
                         output logic [31:0] ma, output logic [31:0] mwd, output logic [31:0] d,
                         output logic [3:0] mk, output logic [4:0] rr);
        int bytes, off;
        longint v, lim;
        bit legal;
        if (wen) legal = (f3 <= 3'd2);
        else     legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bytes = 1 << f3[1:0];
        if (bytes > 4) bytes = 4;
        e = !legal;
`ifdef YSYX_24090005_LSU_MISALIGN_EN
        if (legal && (int'(addr % 4) % bytes) != 0) e = 1'b1;
`endif
        acc = !e;
        off = (int'(addr % 4) / bytes) * bytes;
        ma  = addr & 32'hffff_fffc;
        lim = longint'(1) << (8 * bytes);
        mk  = wen ? 4'(((1 << bytes) - 1) << off) : 4'd0;
        v   = longint'(wdata) % lim;
        mwd = 32'(v * (bytes == 1 ? 64'h0101_0101 : bytes == 2 ? 64'h0001_0001 : 64'h1));
        v   = (longint'(rdata) >> (8 * off)) % lim;
        if (!f3[2] && bytes < 4 && v >= lim / 2) v = v - lim;
        d  = 32'(v);
        rw = 1'b1;
        rr = rd;
        if (wen || e) begin
            d  = 32'd0;
            rw = 1'b0;
            rr = 5'd0;
        end
    endtask

    task automatic op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                      input int rdy_dly, input int rv_dly, input int rsp_dly);
        logic acc, e, rw;
        logic [31:0] ma, mwd, d;
        logic [3:0] mk;
        logic [4:0] rr;
        model(wen, f3, addr, wdata, rdata, rd, acc, e, rw, ma, mwd, d, mk, rr);
        check("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0; req_wen = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        check("busy_req_ready", req_ready, 0);
        if (acc) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check("mem_valid", mem_valid, 1);
                check("mem_addr", mem_addr, ma);
                check("mem_wen", mem_wen, wen);
                check("mem_wmask", mem_wmask, mk);
                if (wen) check("mem_wdata", mem_wdata, mwd);
                check("req_rsp_valid", rsp_valid, 0);
                if (i == rdy_dly) mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
            end
            for (int i = 0; i <= rv_dly; i++) begin
                check("wait_mem_valid", mem_valid, 0);
                check("wait_rsp_valid", rsp_valid, 0);
                if (i == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            check("no_access_mem_valid", mem_valid, 0);
        end
        for (int i = 0; i <= rsp_dly; i++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_err", rsp_err, e);
            check("rsp_wen", rsp_wen, rw);
            check("rsp_rd", rsp_rd, rr);
            check("rsp_data", rsp_data, d);
            check("rsp_req_ready", req_ready, 0);
            check("rsp_mem_valid", mem_valid, 0);
            if (i == rsp_dly) rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        check("post_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", req_ready, 1);
        @(negedge clk);

        // LB sign-extended from top lane, minimum latency
        op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd7, 32'h8a00_0000, 0, 0, 0);
        // SH upper half
        op(1'b1, 3'b001, 32'h8000_0002, 32'h1234_abcd, 5'd9, 32'h0, 1, 2, 1);
        // LW misaligned
        op(1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd3, 32'hdead_beef, 0, 1, 0);
        // illegal load / store funct3
        op(1'b0, 3'b011, 32'h0000_0010, 32'h0, 5'd4, 32'h0, 0, 0, 0);
        op(1'b1, 3'b100, 32'h0000_0010, 32'h5555_aaaa, 5'd4, 32'h0, 0, 0, 1);
        // LHU / LH upper half
        op(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd11, 32'h8001_7fff, 0, 0, 0);
        op(1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd12, 32'h8001_7fff, 2, 3, 0);
        // LBU, SB lane 1, SW; response held 5 cycles
        op(1'b0, 3'b100, 32'h0000_0201, 32'h0, 5'd13, 32'h0000_f200, 0, 0, 5);
        op(1'b1, 3'b000, 32'h0000_0301, 32'hffff_ff5a, 5'd14, 32'h0, 0, 0, 0);
        op(1'b1, 3'b010, 32'h0000_0400, 32'hcafe_f00d, 5'd15, 32'h0, 3, 0, 0);

        // Timeout with TIMEOUT_CYC=4, then late mem_rvalid must be dropped
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_0800; req_rd = 5'd21;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_wait_rsp_valid", rsp_valid, 0);
            @(negedge clk);
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_wen", rsp_wen, 0);
        check("to_rsp_rd", rsp_rd, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_rsp_valid", rsp_valid, 0);
            check("late_req_ready", req_ready, 1);
            @(negedge clk);
        end

        // Reset asserted in WAIT
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0900; req_wdata = 32'h1234_5678; req_rd = 5'd5;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_valid", mem_valid, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        check("arst_rel_req_ready", req_ready, 1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("arst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            op(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
